// File: rtl/neuron_act_unit.sv
// -----------------------------------------------------------------------------
// neuron_act_unit
//
// Activation stage placed after a neuron's multiply-accumulate. It takes the
// signed 2*DATA_WIDTH accumulator and returns a DATA_WIDTH activation exactly
// one clock later. The activation function is fixed at elaboration through
// ACT_TYPE:
//   "relu"            ReLU, saturating positive overflow to 2^(DATA_WIDTH-1)-1
//   "sigmoid_nor"     sigmoid from a 2^S entry ROM indexed by the signed slice x
//   "sigmoid_LU_half" sigmoid from a 2^(S-1) entry ROM, using
//                     sigmoid(-v) = 1 - sigmoid(v) for negative inputs
//   "dummy"           pass the activation slice straight through
// Sigmoid outputs are unsigned Q1.(DATA_WIDTH-1), so 1.0 = 2^(DATA_WIDTH-1).
// ROM contents come from a constant function evaluated at elaboration.
//
// Optional build macro ACT_SAT_EN: when defined, the sigmoid index x and the
// dummy pass-through value saturate whenever the accumulator does not fit the
// slice; when undefined those slices simply wrap. ReLU always saturates.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   sum is valid this cycle
//   sum        in   [2*DATA_WIDTH-1:0] signed accumulator value
//   out        out  [DATA_WIDTH-1:0] activation result (registered)
//   out_valid  out  out is valid (in_valid delayed by one clock)
// -----------------------------------------------------------------------------
module neuron_act_unit #(
    parameter int    DATA_WIDTH       = 16,
    parameter int    WEIGHT_INT_WIDTH = 4,
    parameter int    SIGMOID_SIZE     = 5,
    parameter string ACT_TYPE         = "sigmoid_LU_half"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [2*DATA_WIDTH-1:0] sum,
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    out_valid
);

    localparam int SW        = 2 * DATA_WIDTH;
    localparam int S         = SIGMOID_SIZE;
    localparam int FULL_N    = 2 ** S;
    localparam int HALF_N    = 2 ** (S - 1);
    // MSB of both the activation slice P and the sigmoid index x
    localparam int X_MSB     = SW - 1 - WEIGHT_INT_WIDTH;
    // Table index x represents the real value x / 2^FRAC_BITS
    localparam int FRAC_BITS = S - WEIGHT_INT_WIDTH;

    localparam logic [DATA_WIDTH-1:0] ONE_Q   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [DATA_WIDTH-1:0] out_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_valid_q;

    // Not every accumulator bit feeds every activation mode.
    logic unused_sum_s;
    assign unused_sum_s = ^sum;

    // -------------------------------------------------------------------------
    // Sigmoid table entry for signed index xi:
    //   round(sigmoid(xi / 2^FRAC_BITS) * 2^(DATA_WIDTH-1))
    // exp() is a Taylor series on |v| (converges quickly for the table's range);
    // the sign is folded back in through the sigmoid symmetry.
    // -------------------------------------------------------------------------
    function automatic int sig_entry(input int xi);
        real v;
        real a;
        real term;
        real e;
        real y;
        real scale;
        real one_q;
        scale = 1.0;
        for (int k = 0; k < FRAC_BITS; k++) begin
            scale = scale * 2.0;
        end
        one_q = 1.0;
        for (int k = 0; k < DATA_WIDTH - 1; k++) begin
            one_q = one_q * 2.0;
        end
        v = real'(xi) / scale;
        a = (v < 0.0) ? -v : v;
        term = 1.0;
        e    = 1.0;
        for (int k = 1; k < 64; k++) begin
            term = term * a / real'(k);
            e    = e + term;
        end
        y = (v < 0.0) ? (1.0 / (1.0 + e)) : (e / (1.0 + e));
        // Entries are non-negative, so +0.5 then truncate rounds to nearest.
        return $rtoi(y * one_q + 0.5);
    endfunction

    // Signed sigmoid index x, optionally clamped when sum overflows the slice.
    // The guard bits sum[SW-2 : X_MSB] must all equal the sign for x to be exact.
    function automatic logic [S-1:0] slice_x(input logic [SW-1:0] v);
        logic [S-1:0] x;
        x = v[X_MSB -: S];
`ifdef ACT_SAT_EN
        if (!v[SW-1] && (|v[SW-2 -: WEIGHT_INT_WIDTH])) begin
            x = {1'b0, {(S-1){1'b1}}};
        end else if (v[SW-1] && !(&v[SW-2 -: WEIGHT_INT_WIDTH])) begin
            x = {1'b1, {(S-1){1'b0}}};
        end else begin
            x = v[X_MSB -: S];
        end
`endif
        return x;
    endfunction

    // Pass-through slice P, optionally clamped exactly like x.
    function automatic logic [DATA_WIDTH-1:0] slice_p(input logic [SW-1:0] v);
        logic [DATA_WIDTH-1:0] p;
        p = v[X_MSB -: DATA_WIDTH];
`ifdef ACT_SAT_EN
        if (!v[SW-1] && (|v[SW-2 -: WEIGHT_INT_WIDTH])) begin
            p = MAX_POS;
        end else if (v[SW-1] && !(&v[SW-2 -: WEIGHT_INT_WIDTH])) begin
            p = ONE_Q;
        end else begin
            p = v[X_MSB -: DATA_WIDTH];
        end
`endif
        return p;
    endfunction

    // ReLU: negatives clamp to zero, positives beyond the slice clamp to max.
    function automatic logic [DATA_WIDTH-1:0] relu_f(input logic [SW-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        if (v[SW-1]) begin
            r = {DATA_WIDTH{1'b0}};
        end else if (|v[SW-2 -: WEIGHT_INT_WIDTH]) begin
            r = MAX_POS;
        end else begin
            r = v[X_MSB -: DATA_WIDTH];
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Mode-specific next-state logic
    // -------------------------------------------------------------------------
    if (ACT_TYPE == "relu") begin : g_relu

        // ReLU with saturation.
        always_comb begin
            out_d = relu_f(sum);
        end

    end else if (ACT_TYPE == "sigmoid_nor") begin : g_sig_nor

        logic [DATA_WIDTH-1:0] rom_s [FULL_N];
        logic [S-1:0]          x_s;
        logic [S-1:0]          idx_s;

        for (genvar gi = 0; gi < FULL_N; gi++) begin : g_rom
            localparam int ENTRY = sig_entry(gi - HALF_N);
            assign rom_s[gi] = ENTRY[DATA_WIDTH-1:0];
        end

        // Full-table lookup; x + 2^(S-1) is x with its sign bit inverted.
        always_comb begin
            x_s   = slice_x(sum);
            idx_s = {~x_s[S-1], x_s[S-2:0]};
            out_d = rom_s[idx_s];
        end

    end else if (ACT_TYPE == "sigmoid_LU_half") begin : g_sig_half

        logic [DATA_WIDTH-1:0] rom_s [HALF_N];
        logic [S-1:0]          x_s;
        logic [S-1:0]          mag_s;
        logic [S-2:0]          idx_s;
        logic [DATA_WIDTH-1:0] h_s;

        for (genvar gi = 0; gi < HALF_N; gi++) begin : g_rom
            localparam int ENTRY = sig_entry(gi);
            assign rom_s[gi] = ENTRY[DATA_WIDTH-1:0];
        end

        // Half-table lookup on |x|; negative inputs return 1.0 - H[|x|].
        // |x| = 2^(S-1) (x most negative) has no entry and uses the last one.
        always_comb begin
            x_s   = slice_x(sum);
            mag_s = sum[SW-1] ? -x_s : x_s;
            if (mag_s[S-1]) begin
                idx_s = {(S-1){1'b1}};
            end else begin
                idx_s = mag_s[S-2:0];
            end
            h_s = rom_s[idx_s];
            if (sum[SW-1]) begin
                out_d = ONE_Q - h_s;
            end else begin
                out_d = h_s;
            end
        end

    end else if (ACT_TYPE == "dummy") begin : g_dummy

        // Plain pass-through of the activation slice.
        always_comb begin
            out_d = slice_p(sum);
        end

    end else begin : g_bad_type

        $error("neuron_act_unit: unsupported ACT_TYPE \"%s\"", ACT_TYPE);

        // Drive a defined value; elaboration stops on the error above.
        always_comb begin
            out_d = {DATA_WIDTH{1'b0}};
        end

    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------

    // Result and valid pipeline stage; out follows sum every cycle, valid qualifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= {DATA_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= in_valid;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_act_unit.sv
// -----------------------------------------------------------------------------
// tb_neuron_act_unit
//
// Self-checking bench for neuron_act_unit. One instance per activation mode
// shares clk/rst/in_valid/sum. Each driven vector pushes the expected result
// for one mode onto a scoreboard queue; when out_valid rises the entry is
// popped and compared against that mode's output. Expectations depending on
// ACT_SAT_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_neuron_act_unit;

    localparam int MODE_RELU  = 0;
    localparam int MODE_NOR   = 1;
    localparam int MODE_HALF  = 2;
    localparam int MODE_DUMMY = 3;

    typedef struct {
        int          mode;
        logic [15:0] exp;
        string       tag;
    } sb_item_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] sum;

    logic [15:0] out_relu;
    logic [15:0] out_nor;
    logic [15:0] out_half;
    logic [15:0] out_dummy;
    logic        v_relu;
    logic        v_nor;
    logic        v_half;
    logic        v_dummy;

    sb_item_t sb_q[$];
    int       check_cnt;
    int       pass_cnt;

    neuron_act_unit #(.DATA_WIDTH(16), .WEIGHT_INT_WIDTH(4), .SIGMOID_SIZE(5),
                      .ACT_TYPE("relu")) u_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
        .out(out_relu), .out_valid(v_relu));

    neuron_act_unit #(.DATA_WIDTH(16), .WEIGHT_INT_WIDTH(4), .SIGMOID_SIZE(5),
                      .ACT_TYPE("sigmoid_nor")) u_nor (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
        .out(out_nor), .out_valid(v_nor));

    neuron_act_unit #(.DATA_WIDTH(16), .WEIGHT_INT_WIDTH(4), .SIGMOID_SIZE(5),
                      .ACT_TYPE("sigmoid_LU_half")) u_half (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
        .out(out_half), .out_valid(v_half));

    neuron_act_unit #(.DATA_WIDTH(16), .WEIGHT_INT_WIDTH(4), .SIGMOID_SIZE(5),
                      .ACT_TYPE("dummy")) u_dummy (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
        .out(out_dummy), .out_valid(v_dummy));

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: check valids against the in_valid seen at the edge, then score.
    task automatic step();
        logic        vin;
        logic [15:0] got;
        sb_item_t    it;
        vin = in_valid;
        @(posedge clk);
        #1;
        check_val("out_valid", {28'd0, v_relu, v_nor, v_half, v_dummy}, {28'd0, {4{vin}}});
        if (v_nor) begin
            check_val("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
                it = sb_q.pop_front();
                case (it.mode)
                    MODE_RELU:  got = out_relu;
                    MODE_NOR:   got = out_nor;
                    MODE_HALF:  got = out_half;
                    MODE_DUMMY: got = out_dummy;
                    default:    got = 16'h0000;
                endcase
                check_val(it.tag, {16'd0, got}, {16'd0, it.exp});
            end
        end
    endtask

    task automatic send(input int mode, input logic [31:0] s, input logic [15:0] e,
                        input string tag);
        sb_item_t it;
        in_valid = 1'b1;
        sum      = s;
        it.mode  = mode;
        it.exp   = e;
        it.tag   = tag;
        sb_q.push_back(it);
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_out"}, {out_relu, out_nor}, 32'd0);
        check_val({tag, "_out2"}, {out_half, out_dummy}, 32'd0);
        check_val({tag, "_valid"}, {28'd0, v_relu, v_nor, v_half, v_dummy}, 32'd0);
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        sum       = 32'h0000_0000;

        // Reset state
        #1;
        check_all_zero("reset_init");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // relu, back-to-back over several cycles
        send(MODE_RELU, 32'h0000_5000, 16'h0005, "relu_small");
        send(MODE_RELU, 32'h1000_0000, 16'h7FFF, "relu_sat");
        send(MODE_RELU, 32'hFFFF_F000, 16'h0000, "relu_neg");
        send(MODE_RELU, 32'h0800_0000, 16'h7FFF, "relu_sat_bit27");
        send(MODE_RELU, 32'h07FF_F000, 16'h7FFF, "relu_max_exact");
        idle();

        // sigmoid_nor
        send(MODE_NOR, 32'h0000_0000, 16'd16384, "nor_zero");
        send(MODE_NOR, 32'h0100_0000, 16'd23955, "nor_x2");
        send(MODE_NOR, 32'h0200_0000, 16'd28862, "nor_x4");
        send(MODE_NOR, 32'h0780_0000, 16'd32750, "nor_x15");
        send(MODE_NOR, 32'hFF00_0000, 16'd8813,  "nor_xm2");
        send(MODE_NOR, 32'hF800_0000, 16'd11,    "nor_xm16");
        idle();

        // sigmoid_LU_half
        send(MODE_HALF, 32'h0000_0000, 16'd16384, "half_zero");
        send(MODE_HALF, 32'h0100_0000, 16'd23955, "half_x2");
        send(MODE_HALF, 32'h0780_0000, 16'd32750, "half_x15");
        send(MODE_HALF, 32'hFF00_0000, 16'd8813,  "half_xm2");
        send(MODE_HALF, 32'hF800_0000, 16'd18,    "half_xm16_clamp");

        // dummy
        send(MODE_DUMMY, 32'h0123_4000, 16'h1234, "dummy_pass");

        // Out-of-range accumulators: saturate with ACT_SAT_EN, wrap without
`ifdef ACT_SAT_EN
        send(MODE_NOR,   32'h1000_0000, 16'd32750, "nor_ovf_pos");
        send(MODE_NOR,   32'hE000_0000, 16'd11,    "nor_ovf_neg");
        send(MODE_HALF,  32'h1000_0000, 16'd32750, "half_ovf_pos");
        send(MODE_DUMMY, 32'h1000_0000, 16'h7FFF,  "dummy_ovf_pos");
        send(MODE_DUMMY, 32'hE000_0000, 16'h8000,  "dummy_ovf_neg");
`else
        send(MODE_NOR,   32'h1000_0000, 16'd16384, "nor_wrap_pos");
        send(MODE_NOR,   32'hE000_0000, 16'd16384, "nor_wrap_neg");
        send(MODE_HALF,  32'h1000_0000, 16'd16384, "half_wrap_pos");
        send(MODE_DUMMY, 32'h1000_0000, 16'h0000,  "dummy_wrap_pos");
        send(MODE_DUMMY, 32'hE000_0000, 16'h0000,  "dummy_wrap_neg");
`endif

        // out follows sum even when in_valid is low
        in_valid = 1'b0;
        sum      = 32'h0123_4000;
        step();
        check_val("out_without_valid", {16'd0, out_dummy}, 32'h0000_1234);

        // Reset asserted mid-stream while out_valid is high
        send(MODE_RELU, 32'h0000_5000, 16'h0005, "relu_pre_reset");
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_async");

        // rst dominates in_valid
        in_valid = 1'b1;
        sum      = 32'h0100_0000;
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

        // in_valid pulse after release: valid exactly one cycle later, then low
        send(MODE_HALF, 32'h0100_0000, 16'd23955, "half_post_reset");
        idle();
        idle();

        check_val("sb_drain", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
